// File: rtl/vsmac_feeder_pkg.sv
// Shared types and helpers for the vector-scalar MAC feeder.
package vsmac_feeder_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StClear = 3'd1,
      StRun   = 3'd2,
      StDrain = 3'd3,
      StDone  = 3'd4
   } state_e;

   // Index width for a table of n entries; never narrower than one bit.
   function automatic int unsigned aw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vsmac_feeder_if.sv
// Host write/start bus and MAC-array drive signals of the feeder.
interface vsmac_feeder_if #(
   parameter int unsigned SIZE          = 6,
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned ACCUMULATIONS = 3
);
   localparam int unsigned AW = vsmac_feeder_pkg::aw(ACCUMULATIONS);

   logic                  w_wr_en;
   logic [AW-1:0]         w_wr_addr;
   logic [WIDTH*SIZE-1:0] w_wr_data;
   logic                  x_wr_en;
   logic [AW-1:0]         x_wr_addr;
   logic [WIDTH-1:0]      x_wr_data;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  mac_clr;
   logic                  mac_en;
   logic [WIDTH*SIZE-1:0] mac_a;
   logic [WIDTH-1:0]      mac_b;

   modport master (
      output w_wr_en, w_wr_addr, w_wr_data, x_wr_en, x_wr_addr, x_wr_data, start,
      input  busy, done, mac_clr, mac_en, mac_a, mac_b
   );

   modport slave (
      input  w_wr_en, w_wr_addr, w_wr_data, x_wr_en, x_wr_addr, x_wr_data, start,
      output busy, done, mac_clr, mac_en, mac_a, mac_b
   );

endinterface

// File: rtl/vsmac_feed_regfile.sv
// DEPTH x DW register file: one range-checked synchronous write port,
// one combinational read port, asynchronous clear.
module vsmac_feed_regfile
   import vsmac_feeder_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = aw(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (we && (32'(waddr) < DEPTH)) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      if (32'(raddr) < DEPTH) rdata = mem_q[raddr];
   end

endmodule

// File: rtl/vsmac_feeder.sv
// Sequencer that clears the MAC accumulators, then streams stored weight
// columns and scalars into the MAC array, and reports completion.
module vsmac_feeder
   import vsmac_feeder_pkg::*;
#(
   parameter int unsigned SIZE          = 6,
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned ACCUMULATIONS = 3,
   parameter int unsigned DRAIN_CYCLES  = 1
) (
   input logic           clk,
   input logic           reset,
   vsmac_feeder_if.slave bus
);

   localparam int unsigned AW  = aw(ACCUMULATIONS);
   localparam int unsigned CW  = aw(DRAIN_CYCLES);
   localparam int unsigned WDW = WIDTH * SIZE;
   localparam logic [AW-1:0] KLast = AW'(ACCUMULATIONS - 1);
   localparam logic [CW-1:0] CLast = CW'(DRAIN_CYCLES - 1);

   state_e           state_q, state_d;
   logic [AW-1:0]    k_q, k_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             clr_q, clr_d;
   logic             en_q, en_d;
   logic [WDW-1:0]   a_q, a_d, w_rdata;
   logic [WIDTH-1:0] b_q, b_d, x_rdata;
   logic             idle;

   assign idle = (state_q == StIdle);

   vsmac_feed_regfile #(
      .DEPTH (ACCUMULATIONS),
      .DW    (WDW),
      .AW    (AW)
   ) u_w_bank (
      .clk   (clk),
      .reset (reset),
      .we    (bus.w_wr_en & idle),
      .waddr (bus.w_wr_addr),
      .wdata (bus.w_wr_data),
      .raddr (k_d),
      .rdata (w_rdata)
   );

   vsmac_feed_regfile #(
      .DEPTH (ACCUMULATIONS),
      .DW    (WIDTH),
      .AW    (AW)
   ) u_x_bank (
      .clk   (clk),
      .reset (reset),
      .we    (bus.x_wr_en & idle),
      .waddr (bus.x_wr_addr),
      .wdata (bus.x_wr_data),
      .raddr (k_d),
      .rdata (x_rdata)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StClear;
         StClear: begin
            state_d = StRun;
            k_d     = '0;
         end
         StRun: begin
            if (k_q == KLast) begin
               state_d = StDrain;
               k_d     = '0;
               cnt_d   = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         StDrain: begin
            if (cnt_q == CLast) state_d = StDone;
            else                cnt_d   = cnt_q + 1'b1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      busy_d = state_d inside {StClear, StRun, StDrain};
      done_d = (state_d == StDone);
      clr_d  = (state_d == StClear);
      en_d   = (state_d == StRun);
      a_d    = en_d ? w_rdata : a_q;
      b_d    = en_d ? x_rdata : b_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         k_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         en_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
         en_q    <= en_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.mac_clr = clr_q;
   assign bus.mac_en  = en_q;
   assign bus.mac_a   = a_q;
   assign bus.mac_b   = b_q;

endmodule

// File: tb/tb_vsmac_feeder.sv
// Bench for vsmac_feeder: default instance plus an ACCUMULATIONS=1 instance.
module tb_vsmac_feeder;

   typedef struct packed {
      logic [47:0] a;
      logic [7:0]  b;
   } pair_t;

   typedef struct packed {
      logic [2:0][47:0] w;
      logic [2:0][7:0]  x;
      logic [2:0][47:0] ea;
      logic [2:0][7:0]  eb;
      logic [7:0]       lat;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;

   pair_t       q0[$];
   pair_t       q1[$];
   logic [47:0] wm [2][3];
   logic [7:0]  xm [2][3];
   bit          active [2];
   vec_t        vecs [2];

   vsmac_feeder_if #(.SIZE(6), .WIDTH(8), .ACCUMULATIONS(3)) bus0 ();
   vsmac_feeder_if #(.SIZE(6), .WIDTH(8), .ACCUMULATIONS(1)) bus1 ();

   vsmac_feeder #(
      .SIZE(6), .WIDTH(8), .ACCUMULATIONS(3), .DRAIN_CYCLES(1)
   ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

   vsmac_feeder #(
      .SIZE(6), .WIDTH(8), .ACCUMULATIONS(1), .DRAIN_CYCLES(2)
   ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboards: every enabled MAC cycle must match the next queued pair.
   always @(negedge clk) begin
      pair_t p;
      if (bus0.mac_en === 1'b1) begin
         check("en_clr_excl0", 64'(bus0.mac_clr), 64'd0);
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_en0: got mac_en=1 expected no pending data");
         end else begin
            p = q0.pop_front();
            check("mac_a0", 64'(bus0.mac_a), 64'(p.a));
            check("mac_b0", 64'(bus0.mac_b), 64'(p.b));
         end
      end
      if (bus1.mac_en === 1'b1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_en1: got mac_en=1 expected no pending data");
         end else begin
            p = q1.pop_front();
            check("mac_a1", 64'(bus1.mac_a), 64'(p.a));
            check("mac_b1", 64'(bus1.mac_b), 64'(p.b));
         end
      end
   end

   task automatic write(input int sel, input logic we, input int wa, input logic [47:0] wd,
                        input logic xe, input int xa, input logic [7:0] xd);
      int depth = (sel == 0) ? 3 : 1;
      if (sel == 0) begin
         bus0.w_wr_en = we; bus0.w_wr_addr = 2'(wa); bus0.w_wr_data = wd;
         bus0.x_wr_en = xe; bus0.x_wr_addr = 2'(xa); bus0.x_wr_data = xd;
      end else begin
         bus1.w_wr_en = we; bus1.w_wr_addr = 1'(wa); bus1.w_wr_data = wd;
         bus1.x_wr_en = xe; bus1.x_wr_addr = 1'(xa); bus1.x_wr_data = xd;
      end
      if (!active[sel] && we && wa < depth) wm[sel][wa] = wd;
      if (!active[sel] && xe && xa < depth) xm[sel][xa] = xd;
      @(posedge clk); #1;
      bus0.w_wr_en = 1'b0; bus0.x_wr_en = 1'b0;
      bus1.w_wr_en = 1'b0; bus1.x_wr_en = 1'b0;
   endtask

   task automatic push_model(input int sel, input int acc);
      for (int k = 0; k < acc; k++) begin
         if (sel == 0) q0.push_back({wm[0][k], xm[0][k]});
         else          q1.push_back({wm[1][k], xm[1][k]});
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 3; k++) begin
            wm[s][k] = '0;
            xm[s][k] = '0;
         end
   endtask

   // Pulse start, then check per-cycle clr/en shape, done latency and busy length.
   task automatic run(input int sel, input int acc, input int exp_done);
      bit   seen = 0;
      int   busy_n = 0;
      logic clr, en, dn, bz;
      active[sel] = 1'b1;
      if (sel == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
      @(posedge clk); #1;
      bus0.start = 1'b0; bus1.start = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         clr = (sel == 0) ? bus0.mac_clr : bus1.mac_clr;
         en  = (sel == 0) ? bus0.mac_en  : bus1.mac_en;
         dn  = (sel == 0) ? bus0.done    : bus1.done;
         bz  = (sel == 0) ? bus0.busy    : bus1.busy;
         check($sformatf("clr%0d_c%0d", sel, c), 64'(clr), 64'(c == 1));
         check($sformatf("en%0d_c%0d", sel, c), 64'(en), 64'(c >= 2 && c <= 1 + acc));
         if (bz) busy_n++;
         if (dn) begin
            seen = 1;
            check($sformatf("done_lat%0d", sel), 64'(c), 64'(exp_done));
         end
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL done_timeout%0d: got no done in 40 cycles expected cycle %0d",
                  sel, exp_done);
      end else begin
         check($sformatf("busy_len%0d", sel), 64'(busy_n), 64'(exp_done - 1));
      end
      @(posedge clk); #1;
      active[sel] = 1'b0;
   endtask

   initial begin
      int   done_at [$];
      logic busy_c [30];
      bit   saw_done;

      vecs[0].w  = {48'h80FF7F01807F, 48'hFFFFFFFFFFFF, 48'h0000000000FF};
      vecs[0].x  = {8'h7F, 8'hFF, 8'h80};
      vecs[0].ea = {48'h80FF7F01807F, 48'hFFFFFFFFFFFF, 48'h0000000000FF};
      vecs[0].eb = {8'h7F, 8'hFF, 8'h80};
      vecs[0].lat = 8'd6;
      vecs[1].w  = {48'h1211100F0E0D, 48'h0C0B0A090807, 48'h060504030201};
      vecs[1].x  = {8'h30, 8'h20, 8'h10};
      vecs[1].ea = {48'h1211100F0E0D, 48'h0C0B0A090807, 48'h060504030201};
      vecs[1].eb = {8'h30, 8'h20, 8'h10};
      vecs[1].lat = 8'd6;

      active[0] = 1'b0; active[1] = 1'b0;
      clear_model();
      reset = 1'b1;
      bus0.start = 1'b0; bus0.w_wr_en = 1'b0; bus0.x_wr_en = 1'b0;
      bus0.w_wr_addr = '0; bus0.x_wr_addr = '0; bus0.w_wr_data = '0; bus0.x_wr_data = '0;
      bus1.start = 1'b0; bus1.w_wr_en = 1'b0; bus1.x_wr_en = 1'b0;
      bus1.w_wr_addr = '0; bus1.x_wr_addr = '0; bus1.w_wr_data = '0; bus1.x_wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus0.busy), 64'd0);
      check("rst_done", 64'(bus0.done), 64'd0);
      check("rst_clr", 64'(bus0.mac_clr), 64'd0);
      check("rst_en", 64'(bus0.mac_en), 64'd0);
      check("rst_a", 64'(bus0.mac_a), 64'd0);
      check("rst_b", 64'(bus0.mac_b), 64'd0);
      check("rst1_busy", 64'(bus1.busy), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Table-driven runs; the last entry leaves the bank in the basic pattern.
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 3; k++) write(0, 1'b1, k, vecs[i].w[k], 1'b1, k, vecs[i].x[k]);
         for (int k = 0; k < 3; k++) q0.push_back({vecs[i].ea[k], vecs[i].eb[k]});
         run(0, 3, int'(vecs[i].lat));
      end

      // Out-of-range write while idle, then a write attempt mid-run.
      write(0, 1'b1, 3, 48'hAAAAAAAAAAAA, 1'b1, 3, 8'h55);
      push_model(0, 3);
      fork
         run(0, 3, 6);
         begin
            @(posedge clk); @(posedge clk); #1;
            write(0, 1'b1, 1, 48'hFFFFFFFFFFFF, 1'b1, 1, 8'hEE);
         end
      join
      push_model(0, 3);
      run(0, 3, 6);

      // start held for 12 edges: two runs, one idle cycle between them.
      push_model(0, 3);
      push_model(0, 3);
      active[0] = 1'b1;
      bus0.start = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (c == 11) bus0.start = 1'b0;
         @(negedge clk);
         busy_c[c] = bus0.busy;
         if (bus0.done) done_at.push_back(c);
      end
      @(posedge clk); #1;
      active[0] = 1'b0;
      check("bb_done_count", 64'(done_at.size()), 64'd2);
      if (done_at.size() == 2) begin
         check("bb_first_done", 64'(done_at[0]), 64'd5);
         check("bb_done_gap", 64'(done_at[1] - done_at[0]), 64'd7);
      end
      check("bb_idle_gap", 64'(busy_c[6]), 64'd0);
      check("bb_restart_busy", 64'(busy_c[7]), 64'd1);

      // Reset during the second RUN cycle.
      push_model(0, 3);
      active[0] = 1'b1;
      bus0.start = 1'b1;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 64'(bus0.busy), 64'd0);
      check("mid_rst_en", 64'(bus0.mac_en), 64'd0);
      check("mid_rst_a", 64'(bus0.mac_a), 64'd0);
      check("mid_rst_b", 64'(bus0.mac_b), 64'd0);
      check("mid_rst_done", 64'(bus0.done), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      active[0] = 1'b0;
      q0.delete();
      clear_model();
      saw_done = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus0.done) saw_done = 1;
      end
      check("mid_rst_no_done", 64'(saw_done), 64'd0);
      @(posedge clk); #1;
      push_model(0, 3);
      run(0, 3, 6);

      // ACCUMULATIONS=1, DRAIN_CYCLES=2 instance; address 1 is out of range.
      write(1, 1'b1, 0, 48'h7F80017F8001, 1'b1, 0, 8'hA5);
      write(1, 1'b1, 1, 48'hFFFFFFFFFFFF, 1'b1, 1, 8'hFF);
      push_model(1, 1);
      run(1, 1, 5);

      repeat (2) @(posedge clk);
      check("q0_drained", 64'(q0.size()), 64'd0);
      check("q1_drained", 64'(q1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vsmac_feeder.md
Name: vsmac_feeder

Overview:
- Upstream sequencer for the vector-scalar MAC array stage.
- Holds one layer slice locally: ACCUMULATIONS weight columns of SIZE×WIDTH bits, and ACCUMULATIONS input scalars of WIDTH bits.
- On start, clears the MAC accumulators, then streams column k and scalar k for ACCUMULATIONS consecutive cycles with enable asserted. Signals done after a drain interval.
- Drives the MAC array's a, b, enable and accumulator-clear inputs directly.

Parameters:
- SIZE, 6, elements per weight column (MAC lanes)
- WIDTH, 8, bits per element, fixed-point two's complement
- ACCUMULATIONS, 3, columns/scalars per run (>=1)
- DRAIN_CYCLES, 1, idle cycles after the last enabled cycle before done (>=1)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  reset, asynchronous, active-high
- w_wr_en  in  1  weight column write strobe
- w_wr_addr  in  AW  column index, AW = max(1,clog2(ACCUMULATIONS))
- w_wr_data  in  WIDTH*SIZE  column data, lane i at [WIDTH*i +: WIDTH]
- x_wr_en  in  1  input scalar write strobe
- x_wr_addr  in  AW  scalar index
- x_wr_data  in  WIDTH  scalar data
- start  in  1  begin a run (level sampled on posedge)
- busy  out  1  high from the start acceptance until done
- done  out  1  one-cycle pulse at end of run
- mac_clr  out  1  one-cycle accumulator clear, OR-ed into the MAC array reset at top level
- mac_en  out  1  MAC array enable
- mac_a  out  WIDTH*SIZE  weight column to MAC array
- mac_b  out  WIDTH  scalar to MAC array

Behaviour:
- All outputs are registered. On reset:
  - busy, done, mac_clr and mac_en are 0.
  - mac_a and mac_b are 0.
  - FSM goes to IDLE and the index counter k is 0.
  - Both storage banks clear to 0.
- Writes:
  - Accepted only in IDLE with address < ACCUMULATIONS; take effect at posedge.
  - Out-of-range addresses are ignored.
  - Writes while busy are ignored; stored contents stay unchanged.
  - w and x writes in the same cycle are independent and both accepted.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
  - IDLE: start=1 -> CLEAR; busy=1 from the next cycle.
  - CLEAR, 1 cycle: mac_clr=1, mac_en=0, k<=0 -> RUN.
  - RUN, exactly ACCUMULATIONS cycles: mac_en=1, mac_a=W[k], mac_b=X[k], k increments. When k==ACCUMULATIONS-1 -> DRAIN.
  - DRAIN, DRAIN_CYCLES cycles: mac_en=0, mac_a/mac_b hold their last values -> DONE.
  - DONE, 1 cycle: done=1, busy=0 -> IDLE.
- Latency: start sampled at edge N gives:
  - mac_clr high in cycle N+1
  - mac_en high in cycles N+2 .. N+1+ACCUMULATIONS
  - done high in cycle N+2+ACCUMULATIONS+DRAIN_CYCLES
- start while busy is ignored, with no queuing.
- start held high through DONE: a new run begins from IDLE on the following edge. Back-to-back runs are separated by exactly one IDLE cycle.
- mac_en is never high while mac_clr is high.
- k wraps to 0 on leaving RUN; k never exceeds ACCUMULATIONS-1.
- ACCUMULATIONS=1: RUN lasts one cycle.
- Reset mid-run: everything returns to reset values immediately, no done pulse, and the banks are cleared. After reset the host must reload the banks.
- No arithmetic is done in this block; data passes bit-exact.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, CLEAR=1, RUN=2, DRAIN=3, DONE=4, 3-bit)
  - AW width function
- One sub-module is natural: vsmac_feed_regfile.
  - Parameterised DEPTH×DW register file: one synchronous write port with a range check, one combinational read port, async reset clear.
  - Instantiated twice: weights with DW=WIDTH*SIZE, scalars with DW=WIDTH.

Test Plan:
- Basic run, defaults:
  - Stimulus: write W[0]=0x060504030201, W[1]=0x0C0B0A090807, W[2]=0x1211100F0E0D; X=0x10,0x20,0x30; pulse start.
  - Required: mac_clr for 1 cycle, then mac_en for 3 cycles presenting (W0,0x10), (W1,0x20), (W2,0x30) in order; done exactly 6 cycles after the start edge.
- Write protection:
  - Stimulus: write W[1]=0xFFFFFFFFFFFF mid-run; also write addr 3 while idle.
  - Required: the second run still presents W1=0x0C0B0A090807; addr 3 is ignored.
- Start while busy:
  - Stimulus: assert start every cycle for 12 cycles.
  - Required: exactly two runs, done pulses 7 cycles apart, one IDLE cycle between runs.
- Reset mid-run:
  - Stimulus: assert reset during the second RUN cycle.
  - Required: all outputs 0 same cycle, no done; a new start then streams all-zero data.
- Parameter corner:
  - Stimulus: ACCUMULATIONS=1, DRAIN_CYCLES=2.
  - Required: single mac_en cycle; done 5 cycles after the start edge; busy high for exactly 4 cycles.
